// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite memory front end.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_MEM  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_CAPT  = 2'd2,
        R_RESP  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave that turns write/read transactions into single-cycle strobes
// for a 2**ADDR_WIDTH x 32 memory with a registered read port.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [3:0]                s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [ADDR_WIDTH-1:0]     write_address,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      w_en,
    output logic [ADDR_WIDTH-1:0]     read_address,
    output logic                      out_en,
    input  logic [DATA_WIDTH-1:0]     read_data
);

    wr_state_t                 wr_state;
    rd_state_t                 rd_state;
    logic                      aw_held;
    logic                      w_held;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic [3:0]                wstrb_r;

    logic                      aw_fire;
    logic                      w_fire;
    logic                      aw_have;
    logic                      w_have;
    logic                      wr_go;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_cur;
    logic [DATA_WIDTH-1:0]     wr_data_cur;
    logic [3:0]                wr_strb_cur;
    logic                      wr_oor;
    logic [ADDR_WIDTH-1:0]     wr_idx;
    logic [1:0]                wr_resp;

    logic                      ar_fire;
    logic                      ar_oor;
    logic                      ar_oor_r;
    logic [ADDR_WIDTH-1:0]     ar_idx;
    logic                      unused_addr_bits;

    // Write-side decode: the address/data used are whichever of held or incoming applies.
    always_comb begin
        aw_fire     = s_awvalid && s_awready;
        w_fire      = s_wvalid && s_wready;
        aw_have     = aw_held || aw_fire;
        w_have      = w_held || w_fire;
        wr_go       = (wr_state == W_IDLE) && aw_have && w_have;
        wr_addr_cur = aw_held ? awaddr_r : s_awaddr;
        wr_data_cur = w_held ? wdata_r : s_wdata;
        wr_strb_cur = w_held ? wstrb_r : s_wstrb;
        wr_oor      = |wr_addr_cur[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2];
        wr_idx      = wr_addr_cur[ADDR_WIDTH+1:2];
        if (wr_oor) begin
            wr_resp = RESP_DECERR;
        end else if (wr_strb_cur != 4'hF) begin
            wr_resp = RESP_SLVERR;
        end else begin
            wr_resp = RESP_OKAY;
        end
    end

    // Read-side decode of the incoming AR address.
    always_comb begin
        ar_fire          = s_arvalid && s_arready;
        ar_oor           = |s_araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2];
        ar_idx           = s_araddr[ADDR_WIDTH+1:2];
        unused_addr_bits = ^{s_araddr[1:0], wr_addr_cur[1:0]};
    end

    // Write FSM: w_en and bresp are decided on the edge that enters W_MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state      <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_r      <= {AXI_ADDR_WIDTH{1'b0}};
            wdata_r       <= {DATA_WIDTH{1'b0}};
            wstrb_r       <= 4'h0;
            s_awready     <= 1'b0;
            s_wready      <= 1'b0;
            s_bvalid      <= 1'b0;
            s_bresp       <= 2'b00;
            w_en          <= 1'b0;
            write_address <= {ADDR_WIDTH{1'b0}};
            write_data    <= {DATA_WIDTH{1'b0}};
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        awaddr_r <= s_awaddr;
                        aw_held  <= 1'b1;
                    end
                    if (w_fire) begin
                        wdata_r <= s_wdata;
                        wstrb_r <= s_wstrb;
                        w_held  <= 1'b1;
                    end
                    if (wr_go) begin
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        s_bresp   <= wr_resp;
                        wr_state  <= W_MEM;
                        if (wr_resp == RESP_OKAY) begin
                            w_en          <= 1'b1;
                            write_address <= wr_idx;
                            write_data    <= wr_data_cur;
                        end
                    end else begin
                        s_awready <= !aw_have;
                        s_wready  <= !w_have;
                    end
                end
                W_MEM: begin
                    w_en     <= 1'b0;
                    s_bvalid <= 1'b1;
                    wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                        wr_state  <= W_IDLE;
                    end
                end
                default: begin
                    w_en     <= 1'b0;
                    s_bvalid <= 1'b0;
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: out_en is held back while a write will occupy the memory next cycle,
    // so a colliding read observes the newly written word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state     <= R_IDLE;
            ar_oor_r     <= 1'b0;
            s_arready    <= 1'b0;
            s_rvalid     <= 1'b0;
            s_rdata      <= {DATA_WIDTH{1'b0}};
            s_rresp      <= 2'b00;
            out_en       <= 1'b0;
            read_address <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        s_arready <= 1'b0;
                        ar_oor_r  <= ar_oor;
                        rd_state  <= R_ISSUE;
                        if (!ar_oor) begin
                            read_address <= ar_idx;
                            out_en       <= !wr_go;
                        end
                    end else begin
                        s_arready <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    if (ar_oor_r) begin
                        s_rdata  <= {DATA_WIDTH{1'b0}};
                        s_rresp  <= RESP_DECERR;
                        s_rvalid <= 1'b1;
                        rd_state <= R_RESP;
                    end else if (out_en) begin
                        out_en   <= 1'b0;
                        rd_state <= R_CAPT;
                    end else begin
                        out_en <= !wr_go;
                    end
                end
                R_CAPT: begin
                    s_rdata  <= read_data;
                    s_rresp  <= RESP_OKAY;
                    s_rvalid <= 1'b1;
                    rd_state <= R_RESP;
                end
                R_RESP: begin
                    if (s_rready) begin
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                        rd_state  <= R_IDLE;
                    end
                end
                default: begin
                    out_en   <= 1'b0;
                    s_rvalid <= 1'b0;
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave with a behavioural 32x32 memory behind it.
module tb_axi_lite_mem_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        w_en;
    logic [4:0]  read_address;
    logic        out_en;
    logic [31:0] read_data;

    logic [31:0] mem [32];
    int          cyc = 0;
    int          wen_count = 0;
    int          oen_count = 0;
    int          wen_cyc = 0;
    int          oen_cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    axi_lite_mem_slave dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .write_address(write_address), .write_data(write_data), .w_en(w_en),
        .read_address(read_address), .out_en(out_en), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // Memory model plus strobe monitor; cyc numbers the cycle ending at this edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (w_en) begin
            mem[write_address] <= write_data;
            wen_count = wen_count + 1;
            wen_cyc   = cyc;
        end
        if (out_en) begin
            read_data <= mem[read_address];
            oen_count = oen_count + 1;
            oen_cyc   = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present AW and/or W and drop each once its handshake has taken place.
    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit do_aw, input bit do_w);
        logic a, w;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = do_aw; s_wvalid = do_w;
        for (int i = 0; i < 30; i++) begin
            if (!(s_awvalid || s_wvalid)) break;
            a = s_awvalid && s_awready;
            w = s_wvalid && s_wready;
            @(negedge clk);
            if (a) s_awvalid = 1'b0;
            if (w) s_wvalid = 1'b0;
        end
        check_val("aw_w_accept", {30'd0, s_awvalid, s_wvalid}, 32'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit got = 1'b0;
        resp = 2'b01;
        s_bready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (s_bvalid) begin resp = s_bresp; got = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        s_bready = 1'b0;
        check_val("b_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
        bit got = 1'b0;
        data = 32'hxxxxxxxx; resp = 2'b01;
        s_rready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (s_rvalid) begin data = s_rdata; resp = s_rresp; got = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        s_rready = 1'b0;
        check_val("r_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic a;
        s_araddr = addr; s_arvalid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a = s_arready;
            @(negedge clk);
            if (a) break;
        end
        s_arvalid = 1'b0;
        wait_r(data, resp);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;
        int          snap;
        for (int i = 0; i < 32; i++) mem[i] = {16'h0BAD, 16'(i)};
        read_data = 32'd0;
        reset = 1'b1;
        s_awaddr = 32'd0; s_awvalid = 1'b0; s_wdata = 32'd0; s_wstrb = 4'h0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = 32'd0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
        check_val("rst_valid", {28'd0, s_bvalid, s_rvalid, w_en, out_en}, 32'd0);
        check_val("rst_rdata", s_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

        // 1: AW and W together, exact latencies on both channels
        s_awaddr = 32'h08; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check_val("t1_wen", {31'd0, w_en}, 32'd1);
        check_val("t1_waddr", {27'd0, write_address}, 32'd2);
        check_val("t1_wdata", write_data, 32'hDEADBEEF);
        check_val("t1_bvalid_c1", {31'd0, s_bvalid}, 32'd0);
        @(negedge clk);
        check_val("t1_wen_c2", {31'd0, w_en}, 32'd0);
        check_val("t1_bvalid", {31'd0, s_bvalid}, 32'd1);
        check_val("t1_bresp", {30'd0, s_bresp}, 32'd0);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        check_val("t1_bvalid_drop", {31'd0, s_bvalid}, 32'd0);
        s_araddr = 32'h08; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        check_val("t1_oen", {31'd0, out_en}, 32'd1);
        check_val("t1_raddr", {27'd0, read_address}, 32'd2);
        @(negedge clk);
        check_val("t1_rvalid_c2", {31'd0, s_rvalid}, 32'd0);
        @(negedge clk);
        check_val("t1_rvalid", {31'd0, s_rvalid}, 32'd1);
        check_val("t1_rdata", s_rdata, 32'hDEADBEEF);
        check_val("t1_rresp", {30'd0, s_rresp}, 32'd0);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;

        // 2: W three cycles ahead of AW
        snap = wen_count;
        send_aw_w(32'h0, 32'h12345678, 4'hF, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_val("t2_no_early_wen", wen_count - snap, 32'd0);
        send_aw_w(32'h7C, 32'h0, 4'h0, 1'b1, 1'b0);
        wait_b(br);
        check_val("t2_bresp", {30'd0, br}, 32'd0);
        check_val("t2_wen_count", wen_count - snap, 32'd1);
        check_val("t2_waddr", {27'd0, write_address}, 32'd31);
        do_read(32'h7C, rd, rr);
        check_val("t2_rdata", rd, 32'h12345678);

        // 3: partial strobe is refused and leaves memory untouched
        snap = wen_count;
        send_aw_w(32'h10, 32'hFFFFFFFF, 4'h3, 1'b1, 1'b1);
        wait_b(br);
        check_val("t3_bresp", {30'd0, br}, 32'd2);
        check_val("t3_no_wen", wen_count - snap, 32'd0);
        do_read(32'h10, rd, rr);
        check_val("t3_rdata", rd, 32'h0BAD0004);
        check_val("t3_rresp", {30'd0, rr}, 32'd0);

        // 4: read and write of the same word in the same cycle
        s_awaddr = 32'h20; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF; s_araddr = 32'h20;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        wait_b(br);
        wait_r(rd, rr);
        check_val("t4_bresp", {30'd0, br}, 32'd0);
        check_val("t4_oen_after_wen", oen_cyc - wen_cyc, 32'd1);
        check_val("t4_rdata", rd, 32'hA5A5A5A5);

        // 5: out-of-range read, response held while rready is low
        snap = oen_count;
        s_araddr = 32'h100; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (s_rvalid) break;
            @(negedge clk);
        end
        check_val("t5_rvalid", {31'd0, s_rvalid}, 32'd1);
        check_val("t5_rresp", {30'd0, s_rresp}, 32'd3);
        check_val("t5_rdata", s_rdata, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t5_hold", {29'd0, s_rvalid, s_rresp}, 32'd7);
        end
        check_val("t5_no_oen", oen_count - snap, 32'd0);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;

        // 6: reset while a write response is pending
        send_aw_w(32'h0C, 32'h11111111, 4'hF, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (s_bvalid) break;
            @(negedge clk);
        end
        check_val("t6_bvalid_pre", {31'd0, s_bvalid}, 32'd1);
        reset = 1'b1;
        snap = wen_count;
        @(negedge clk);
        check_val("t6_bvalid_rst", {31'd0, s_bvalid}, 32'd0);
        check_val("t6_awready_rst", {31'd0, s_awready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("t6_awready_rel", {31'd0, s_awready}, 32'd1);
        repeat (4) @(negedge clk);
        check_val("t6_no_wen", wen_count - snap, 32'd0);
        check_val("t6_bvalid_after", {31'd0, s_bvalid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
